inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction source for the v1 CPU datapath (inst ROM + register file + ALU). It sits upstream of the decoder and produces the 16-bit `inst` word that the datapath consumes.
- Accepts a program over a valid/ready load port into internal program RAM.
- On `start`, fetches and issues words one per cycle. Handles JMP and HLT internally.
- Flags every issued word with `inst_valid`; the datapath must gate register writes on it.

Parameters:
ADDR_W, 8, program RAM address width / width of `pc`
DEPTH, 2**ADDR_W, program RAM words
INST_W, 16, instruction width (format: [15:12] op, [11:8] rd, [7:4] rs1, [3:0] rs2; imm = [7:0])

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
load_valid  in  1  load beat present
load_ready  out  1  block can accept a load beat
load_data  in  INST_W  program word
load_last  in  1  marks final word of program
start  in  1  begin or restart execution at pc=0
clear  in  1  discard program, return to IDLE
stall  in  1  hold issue stage this cycle
inst  out  INST_W  issued instruction (registered)
inst_valid  out  1  `inst` is a real instruction this cycle
pc  out  ADDR_W  address of next word to fetch
halted  out  1  in HALT state

Behaviour:
- Reset: state=IDLE, pc=0, wptr=0, prog_len=0, inst=0, inst_valid=0, halted=0. RAM contents are not cleared. Reset mid-load or mid-run behaves identically.
- States are IDLE, LOAD, RUN, HALT. `load_ready` is combinational: (state==IDLE or LOAD) and wptr<DEPTH.
- Load handshake: a beat is accepted when load_valid && load_ready. On acceptance:
  - mem[wptr]<=load_data; wptr++; state=LOAD.
  - If load_last, or wptr==DEPTH-1: prog_len<=wptr+1, state=IDLE.
- Once wptr reaches DEPTH, load_ready=0 and further beats stall upstream.
- `start` is honoured only in IDLE and HALT:
  - prog_len==0 -> HALT.
  - Otherwise -> RUN with pc=0 and inst_valid=0.
  - start in LOAD is ignored.
  - If start and an accepted beat coincide, the beat wins and start is ignored.
- RUN, each edge with stall=0, fetching word w=mem[pc]:
  - If pc>=prog_len: state=HALT, inst_valid<=0 (fell off end).
  - Else if w[15:12]==OP_HLT (0xD): state=HALT, inst_valid<=0, pc unchanged.
  - Else if w[15:12]==OP_JMP (0xE): pc<=w[7:0] (truncated to ADDR_W), inst_valid<=0 (one bubble), inst unchanged.
  - Else: inst<=w, inst_valid<=1, pc<=pc+1. pc wraps modulo DEPTH, but the end check fires first.
- Latency: the first issued word appears with inst_valid=1 on the 2nd edge after `start` is sampled (edge 1 enters RUN, edge 2 issues mem[0]). Steady state is one word per cycle.
- stall=1 in RUN: inst, inst_valid, pc and state all hold. stall is ignored outside RUN.
- HALT: halted=1, inst_valid=0, and inst holds its last value.
- clear, in any state except during rst: state=IDLE, wptr=0, prog_len=0, pc=0, inst_valid=0. clear has priority over start and over a load beat in the same cycle.
- A JMP target >= prog_len halts on the next fetch via the end check.

Decomposition:
- Shared package `cpu_pkg`:
  - INST_W.
  - Opcode constants: OP_ADD=4'h0, OP_SUB=4'h1, OP_HLT=4'hD, OP_JMP=4'hE, OP_LDI=4'hF.
  - Field-slice helper functions for op/rd/rs1/rs2/imm.
  - fetch_state_t enum {IDLE, LOAD, RUN, HALT}.
  - The existing inst ROM and register-file bench should import the same opcode constants.
- One sub-module, `prog_ram`: one write port (we, waddr, wdata) and an asynchronous read port. The DEPTHxINST_W array is inferred. The fetch FSM and issue register stay in inst_fetch.

Test Plan:
- Basic run: load F00A, F102, 0001, F103, 1001 (last on 5th), then pulse start. Required response:
  - inst_valid=1 for 5 consecutive cycles with exactly that sequence.
  - Next cycle: halted=1, inst_valid=0, pc=5.
  - A connected datapath ends with x0=9, x1=3.
- Jump loop: load F00A, E000 (last), start. Required response:
  - inst alternates F00A (valid=1) and a bubble (valid=0) indefinitely.
  - pc toggles 1,0,1,0; halted stays 0.
- HLT and restart: load F001, D000, F002 (last), start.
  - Only F001 is issued; then halted=1 and pc=1.
  - A second start reissues F001 and halts again. F002 is never issued.
- Stall: during the basic run, hold stall=1 for 3 cycles after the 2nd word.
  - inst stays F102 with inst_valid=1 and pc=2 held throughout.
  - The sequence then resumes 0001 with no word dropped or duplicated.
- Load boundaries: with DEPTH=4, stream 6 beats and no last.
  - load_ready drops after 4 accepts; prog_len=4.
  - Same-cycle start+beat: start is ignored. start with an empty program goes straight to HALT.
- Reset/clear mid-run: assert rst during the basic run at pc=3.
  - Next cycle: IDLE, inst_valid=0, pc=0, prog_len=0; start then goes straight to HALT.
  - clear shows the same result and overrides a same-cycle start.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction width, opcodes, field helpers, fetch states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package cpu_pkg;

    localparam int INST_W = 16;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_HLT = 4'hD;
    localparam logic [3:0] OP_JMP = 4'hE;
    localparam logic [3:0] OP_LDI = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

    function automatic logic [3:0] op_of(input logic [INST_W-1:0] w);
        return w[15:12];
    endfunction

    function automatic logic [3:0] rd_of(input logic [INST_W-1:0] w);
        return w[11:8];
    endfunction

    function automatic logic [3:0] rs1_of(input logic [INST_W-1:0] w);
        return w[7:4];
    endfunction

    function automatic logic [3:0] rs2_of(input logic [INST_W-1:0] w);
        return w[3:0];
    endfunction

    function automatic logic [7:0] imm_of(input logic [INST_W-1:0] w);
        return w[7:0];
    endfunction

endpackage

// File: rtl/prog_ram.sv
// Program RAM: one synchronous write port, one asynchronous read port.
// Latency: write lands on the next edge; read is combinational.
// Backpressure: none, always accepts a write.
module prog_ram
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [INST_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [INST_W-1:0] rdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [INST_W-1:0] mem [DEPTH];

    // Storage is never reset so a program survives rst/clear until rewritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: loads a program, then issues one word per cycle handling JMP/HLT.
// Latency: first word valid on the 2nd edge after start; then one word per cycle.
// Backpressure: load_ready low outside IDLE/LOAD or when RAM is full; stall holds issue.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [INST_W-1:0] load_data,
    input  logic              load_last,
    input  logic              start,
    input  logic              clear,
    input  logic              stall,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W:0]   wptr_q, wptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [INST_W-1:0] fetch_word;
    logic              beat;

    // wptr is one bit wider than the address so "full" is representable.
    assign load_ready = ((state_q == IDLE) || (state_q == LOAD)) && (wptr_q < DEPTH_C);
    assign beat       = load_valid && load_ready;

    prog_ram #(
        .ADDR_W (ADDR_W)
    ) u_prog_ram (
        .clk   (clk),
        .we    (beat && !clear && !rst),
        .waddr (wptr_q[ADDR_W-1:0]),
        .wdata (load_data),
        .raddr (pc_q),
        .rdata (fetch_word)
    );

    // Next-state logic: clear beats a load beat, a load beat beats start.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        wptr_d       = wptr_q;
        prog_len_d   = prog_len_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;

        if (clear) begin
            state_d      = IDLE;
            wptr_d       = '0;
            prog_len_d   = '0;
            pc_d         = '0;
            inst_valid_d = 1'b0;
        end else if (beat) begin
            wptr_d  = wptr_q + 1'b1;
            state_d = LOAD;
            if (load_last || (wptr_q == LAST_C)) begin
                prog_len_d = wptr_q + 1'b1;
                state_d    = IDLE;
            end
        end else if (start && ((state_q == IDLE) || (state_q == HALT))) begin
            if (prog_len_q == '0) begin
                state_d = HALT;
            end else begin
                state_d      = RUN;
                pc_d         = '0;
                inst_valid_d = 1'b0;
            end
        end else if ((state_q == RUN) && !stall) begin
            // End-of-program check comes before decoding so a wrapped or
            // out-of-range pc never issues a stale RAM word.
            if ({1'b0, pc_q} >= prog_len_q) begin
                state_d      = HALT;
                inst_valid_d = 1'b0;
            end else if (op_of(fetch_word) == OP_HLT) begin
                state_d      = HALT;
                inst_valid_d = 1'b0;
            end else if (op_of(fetch_word) == OP_JMP) begin
                pc_d         = ADDR_W'(imm_of(fetch_word));
                inst_valid_d = 1'b0;
            end else begin
                inst_d       = fetch_word;
                inst_valid_d = 1'b1;
                pc_d         = pc_q + 1'b1;
            end
        end
    end

    // State and issue registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pc_q         <= '0;
            wptr_q       <= '0;
            prog_len_q   <= '0;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wptr_q       <= wptr_d;
            prog_len_q   <= prog_len_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign halted     = (state_q == HALT);

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed program runs plus randomized programs against a reference model.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: exercises load_ready on a 4-deep instance and stall on the 256-deep one.
module tb_inst_fetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 256-word instance
    logic        rst, load_valid, load_last, start, clear, stall;
    logic [15:0] load_data;
    logic        load_ready, inst_valid, halted;
    logic [15:0] inst;
    logic [7:0]  pc;

    // 4-word instance
    logic        s_rst, s_load_valid, s_load_last, s_start, s_clear, s_stall;
    logic [15:0] s_load_data;
    logic        s_load_ready, s_inst_valid, s_halted;
    logic [15:0] s_inst;
    logic [1:0]  s_pc;

    inst_fetch #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .start(start), .clear(clear),
        .stall(stall), .inst(inst), .inst_valid(inst_valid), .pc(pc), .halted(halted)
    );

    inst_fetch #(.ADDR_W(2)) dut4 (
        .clk(clk), .rst(s_rst), .load_valid(s_load_valid), .load_ready(s_load_ready),
        .load_data(s_load_data), .load_last(s_load_last), .start(s_start), .clear(s_clear),
        .stall(s_stall), .inst(s_inst), .inst_valid(s_inst_valid), .pc(s_pc), .halted(s_halted)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: program held as an array, execution tracked as
    // "what the next fetch does" with plain integers.
    localparam int M_IDLE = 0, M_LOAD = 1, M_RUN = 2, M_HALT = 3;
    logic [15:0] m_mem [256];
    int          m_mode, m_wptr, m_len, m_pc;
    logic [15:0] m_inst;
    bit          m_valid;

    // Toy datapath fed by issued words (LDI/ADD/SUB only).
    logic [7:0] xr [16];

    task automatic model_update();
        logic [15:0] w;
        bit rdy;
        rdy = (m_mode == M_IDLE || m_mode == M_LOAD) && (m_wptr < 256);
        if (rst) begin
            m_mode = M_IDLE; m_pc = 0; m_wptr = 0; m_len = 0; m_inst = 16'h0; m_valid = 0;
        end else if (clear) begin
            m_mode = M_IDLE; m_wptr = 0; m_len = 0; m_pc = 0; m_valid = 0;
        end else if (load_valid && rdy) begin
            m_mem[m_wptr] = load_data;
            if (load_last || m_wptr == 255) begin
                m_len  = m_wptr + 1;
                m_mode = M_IDLE;
            end else begin
                m_mode = M_LOAD;
            end
            m_wptr++;
        end else if (start && (m_mode == M_IDLE || m_mode == M_HALT)) begin
            if (m_len == 0) m_mode = M_HALT;
            else begin m_mode = M_RUN; m_pc = 0; m_valid = 0; end
        end else if (m_mode == M_RUN && !stall) begin
            if (m_pc >= m_len) begin
                m_mode = M_HALT; m_valid = 0;
            end else begin
                w = m_mem[m_pc];
                if (w[15:12] == 4'hD) begin
                    m_mode = M_HALT; m_valid = 0;
                end else if (w[15:12] == 4'hE) begin
                    m_pc = int'(w[7:0]); m_valid = 0;
                end else begin
                    m_inst = w; m_valid = 1; m_pc = (m_pc + 1) % 256;
                end
            end
        end
    endtask

    // One clock on the 256-word instance, with model update and full compare.
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        chk("m_inst", 32'(inst), 32'(m_inst));
        chk("m_valid", 32'(inst_valid), 32'(m_valid));
        chk("m_pc", 32'(pc), 32'(m_pc));
        chk("m_halted", 32'(halted), 32'(m_mode == M_HALT));
        chk("m_ready", 32'(load_ready), 32'((m_mode <= M_LOAD) && (m_wptr < 256)));
        if (inst_valid) begin
            case (op_of(inst))
                OP_LDI: xr[rd_of(inst)] = imm_of(inst);
                OP_ADD: xr[rd_of(inst)] = xr[rs1_of(inst)] + xr[rs2_of(inst)];
                OP_SUB: xr[rd_of(inst)] = xr[rs1_of(inst)] - xr[rs2_of(inst)];
                default: ;
            endcase
        end
    endtask

    task automatic step4();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [15:0] w, input bit last);
        load_valid = 1'b1; load_data = w; load_last = last;
        step();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    logic [15:0] basic [5];
    int acc;

    initial begin
        basic[0] = 16'hF00A; basic[1] = 16'hF102; basic[2] = 16'h0001;
        basic[3] = 16'hF103; basic[4] = 16'h1001;
        rst = 1'b1; load_valid = 0; load_last = 0; load_data = 0;
        start = 0; clear = 0; stall = 0;
        s_rst = 1'b1; s_load_valid = 0; s_load_last = 0; s_load_data = 0;
        s_start = 0; s_clear = 0; s_stall = 0;
        for (int i = 0; i < 16; i++) xr[i] = 8'h0;
        m_mode = M_IDLE; m_wptr = 0; m_len = 0; m_pc = 0; m_inst = 0; m_valid = 0;

        // ---- 4-word instance: load boundaries (main instance held in reset) ----
        step4();
        s_rst = 1'b0;
        chk("s_reset_ready", 32'(s_load_ready), 32'd1);
        chk("s_reset_halted", 32'(s_halted), 32'd0);
        s_start = 1'b1; step4(); s_start = 1'b0;
        chk("s_empty_start_halted", 32'(s_halted), 32'd1);
        chk("s_halt_ready", 32'(s_load_ready), 32'd0);
        s_clear = 1'b1; step4(); s_clear = 1'b0;
        chk("s_clear_halted", 32'(s_halted), 32'd0);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            s_load_valid = 1'b1; s_load_data = 16'hF001 + 16'(i); s_start = (i == 0);
            if (s_load_ready) acc++;
            step4();
            s_start = 1'b0;
            if (i == 0) begin
                chk("s_start_beat_halted", 32'(s_halted), 32'd0);
                chk("s_start_beat_ready", 32'(s_load_ready), 32'd1);
            end
        end
        s_load_valid = 1'b0;
        chk("s_accepts", 32'(acc), 32'd4);
        chk("s_full_ready", 32'(s_load_ready), 32'd0);
        s_start = 1'b1; step4(); s_start = 1'b0;
        chk("s_run_entry_valid", 32'(s_inst_valid), 32'd0);
        for (int j = 0; j < 6; j++) begin
            step4();
            chk("s_run_inst", 32'(s_inst), 32'(16'hF001 + 16'(j % 4)));
            chk("s_run_valid", 32'(s_inst_valid), 32'd1);
            chk("s_run_pc", 32'(s_pc), 32'((j + 1) % 4));
        end
        s_rst = 1'b1;

        // ---- main instance: reset state ----
        step();
        rst = 1'b0;
        chk("reset_inst", 32'(inst), 32'h0);
        chk("reset_valid", 32'(inst_valid), 32'd0);
        chk("reset_pc", 32'(pc), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        chk("reset_ready", 32'(load_ready), 32'd1);

        // ---- basic run ----
        for (int i = 0; i < 5; i++) load_word(basic[i], i == 4);
        for (int i = 0; i < 16; i++) xr[i] = 8'h0;
        pulse_start();
        chk("basic_entry_valid", 32'(inst_valid), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("basic_inst", 32'(inst), 32'(basic[i]));
            chk("basic_valid", 32'(inst_valid), 32'd1);
        end
        step();
        chk("basic_end_halted", 32'(halted), 32'd1);
        chk("basic_end_valid", 32'(inst_valid), 32'd0);
        chk("basic_end_pc", 32'(pc), 32'd5);
        chk("basic_x0", 32'(xr[0]), 32'd9);
        chk("basic_x1", 32'(xr[1]), 32'd3);

        // ---- stall after 2nd word ----
        pulse_start();
        step(); step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_inst", 32'(inst), 32'hF102);
            chk("stall_valid", 32'(inst_valid), 32'd1);
            chk("stall_pc", 32'(pc), 32'd2);
        end
        stall = 1'b0;
        for (int i = 2; i < 5; i++) begin
            step();
            chk("resume_inst", 32'(inst), 32'(basic[i]));
        end
        step();
        chk("resume_halted", 32'(halted), 32'd1);

        // ---- reset mid-run ----
        pulse_start();
        step(); step(); step();
        chk("midrun_pc", 32'(pc), 32'd3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        pulse_start();
        chk("rst_start_halted", 32'(halted), 32'd1);

        // ---- clear mid-run, overriding start ----
        pulse_clear();
        for (int i = 0; i < 5; i++) load_word(basic[i], i == 4);
        pulse_start();
        step(); step();
        clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
        chk("clr_valid", 32'(inst_valid), 32'd0);
        chk("clr_pc", 32'(pc), 32'd0);
        chk("clr_halted", 32'(halted), 32'd0);
        step();
        chk("clr_idle_halted", 32'(halted), 32'd0);
        pulse_start();
        chk("clr_start_halted", 32'(halted), 32'd1);

        // ---- jump loop ----
        pulse_clear();
        load_word(16'hF00A, 1'b0);
        load_word(16'hE000, 1'b1);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            step();
            chk("jmp_inst", 32'(inst), 32'hF00A);
            chk("jmp_valid", 32'(inst_valid), 32'((k % 2) == 0));
            chk("jmp_pc", 32'(pc), 32'((k % 2) == 0));
            chk("jmp_halted", 32'(halted), 32'd0);
        end

        // ---- HLT and restart ----
        pulse_clear();
        load_word(16'hF001, 1'b0);
        load_word(16'hD000, 1'b0);
        load_word(16'hF002, 1'b1);
        for (int r = 0; r < 2; r++) begin
            pulse_start();
            step();
            chk("hlt_inst", 32'(inst), 32'hF001);
            chk("hlt_valid", 32'(inst_valid), 32'd1);
            step();
            chk("hlt_halted", 32'(halted), 32'd1);
            chk("hlt_pc", 32'(pc), 32'd1);
            chk("hlt_hold_inst", 32'(inst), 32'hF001);
        end
        step();
        chk("hlt_never_f002", 32'(inst), 32'hF001);

        // ---- randomized programs against the model ----
        for (int it = 0; it < 10; it++) begin
            int n;
            logic [15:0] w;
            pulse_clear();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                w = 16'($urandom_range(0, 65535));
                if (w[15:12] == 4'hE) w[7:0] = 8'($urandom_range(0, n + 1));
                while ($urandom_range(0, 3) == 0) step();
                load_word(w, i == n - 1);
            end
            pulse_start();
            for (int c = 0; c < 40; c++) begin
                stall = ($urandom_range(0, 3) == 0);
                start = ($urandom_range(0, 15) == 0);
                step();
            end
            stall = 1'b0; start = 1'b0;
        end
        pulse_clear();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
